// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for a shared UART transmitter.
// Picks one requester while idle, latches its byte, fires a single start pulse,
// then follows the transmitter busy/done handshake. A watchdog gives the
// datapath back if the transmitter never raises busy after a start.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          i_clock,
    input  logic                          i_resetL,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic                          i_tx_busy,
    input  logic                          i_tx_done,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_tx_start,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic [$clog2(NUM_REQ)-1:0]    o_owner,
    output logic                          o_active,
    output logic                          o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    start_q, start_d;
    logic                    timeout_q, timeout_d;
    logic                    active_q, active_d;

    logic                    win_vld;
    logic [IDX_W-1:0]        win_idx;
    logic [DATA_WIDTH-1:0]   win_data;

    // Round-robin search starting just after the previous owner, wrapping around.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_data = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(last_q) + i) % NUM_REQ;
            if (!win_vld && i_req[idx]) begin
                win_vld  = 1'b1;
                win_idx  = IDX_W'(idx);
                win_data = i_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        data_d    = data_q;
        wd_d      = wd_q;
        grant_d   = '0;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    data_d  = win_data;
                    start_d = 1'b1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        grant_d[k] = (win_idx == IDX_W'(k));
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_tx_done) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            WAIT_DONE: begin
                // A busy drop without done is deliberately ignored here.
                if (i_tx_done) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transfer without pulses.
    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            data_q    <= '0;
            wd_q      <= '0;
            grant_q   <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            data_q    <= data_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            active_q  <= active_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_owner    = owner_q;
    assign o_active   = active_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        i_clock;
    logic        i_resetL;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic [3:0]  o_grant;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [1:0]  o_owner;
    logic        o_active;
    logic        o_timeout;

    int n_chk;
    int n_pass;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock    (i_clock),
        .i_resetL   (i_resetL),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_tx_busy  (i_tx_busy),
        .i_tx_done  (i_tx_done),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_owner    (o_owner),
        .o_active   (o_active),
        .o_timeout  (o_timeout)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Bounded wait for a start pulse, then verify the winner.
    task automatic wait_start(input string tag, input logic [3:0] exp_grant,
                              input logic [1:0] exp_owner, input logic [7:0] exp_data);
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_tx_start) break;
        end
        chk({tag, "_start"}, 32'(o_tx_start), 32'd1);
        chk({tag, "_grant"}, 32'(o_grant), 32'(exp_grant));
        chk({tag, "_owner"}, 32'(o_owner), 32'(exp_owner));
        chk({tag, "_data"},  32'(o_tx_data), 32'(exp_data));
        chk({tag, "_active"}, 32'(o_active), 32'd1);
    endtask

    // Transmitter model for a well-behaved frame, starting in the LOAD cycle.
    task automatic finish_frame(input string tag);
        i_tx_busy = 1'b1;
        step();
        chk({tag, "_one_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "_grant_clr"}, 32'(o_grant), 32'd0);
        step();
        step();
        chk({tag, "_busy_active"}, 32'(o_active), 32'd1);
        i_tx_done = 1'b1;
        i_tx_busy = 1'b0;
        step();
        i_tx_done = 1'b0;
        chk({tag, "_idle"}, 32'(o_active), 32'd0);
        chk({tag, "_gap"},  32'(o_tx_start), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   32'(o_grant), 32'd0);
        chk({tag, "_start"},   32'(o_tx_start), 32'd0);
        chk({tag, "_data"},    32'(o_tx_data), 32'd0);
        chk({tag, "_owner"},   32'(o_owner), 32'd0);
        chk({tag, "_active"},  32'(o_active), 32'd0);
        chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        i_resetL  = 1'b0;
        i_req     = 4'b0000;
        i_data    = 32'h0;
        i_tx_busy = 1'b0;
        i_tx_done = 1'b0;

        // Reset state
        step();
        step();
        chk_all_zero("rst");
        i_resetL = 1'b1;

        // Single request from requester 2
        i_req  = 4'b0100;
        i_data = 32'h00A5_0000;
        step();
        chk("t1_grant", 32'(o_grant), 32'h4);
        chk("t1_start", 32'(o_tx_start), 32'd1);
        chk("t1_data",  32'(o_tx_data), 32'hA5);
        chk("t1_owner", 32'(o_owner), 32'd2);
        i_req = 4'b0000;
        finish_frame("t1");
        chk("t1_hold_data",  32'(o_tx_data), 32'hA5);
        chk("t1_hold_owner", 32'(o_owner), 32'd2);

        // All requesting after a fresh reset: 0,1,2,3,0
        i_resetL = 1'b0;
        step();
        i_resetL = 1'b1;
        i_req  = 4'b1111;
        i_data = 32'h4433_2211;
        wait_start("rr0", 4'b0001, 2'd0, 8'h11);
        finish_frame("rr0");
        wait_start("rr1", 4'b0010, 2'd1, 8'h22);
        finish_frame("rr1");
        wait_start("rr2", 4'b0100, 2'd2, 8'h33);
        finish_frame("rr2");
        wait_start("rr3", 4'b1000, 2'd3, 8'h44);
        finish_frame("rr3");
        wait_start("rr4", 4'b0001, 2'd0, 8'h11);
        finish_frame("rr4");

        // Watchdog: grant to 1, busy never rises
        i_req = 4'b0010;
        wait_start("wd", 4'b0010, 2'd1, 8'h22);
        i_req = 4'b0011;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("wd_no_pulse", 32'(o_timeout), 32'd0);
        end
        step();
        chk("wd_pulse",  32'(o_timeout), 32'd1);
        chk("wd_idle",   32'(o_active), 32'd0);
        chk("wd_nostart", 32'(o_tx_start), 32'd0);
        step();
        chk("wd_once",   32'(o_timeout), 32'd0);
        chk("wd_next_grant", 32'(o_grant), 32'h1);
        chk("wd_next_owner", 32'(o_owner), 32'd0);

        // Done arriving in WAIT_ACK without busy
        i_req = 4'b0000;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("ack_done_idle", 32'(o_active), 32'd0);
        chk("ack_done_no_to", 32'(o_timeout), 32'd0);
        i_req = 4'b0011;
        wait_start("ptr", 4'b0010, 2'd1, 8'h22);

        // Requests changing during WAIT_DONE are ignored
        i_req = 4'b0000;
        i_tx_busy = 1'b1;
        step();
        step();
        i_req = 4'b1100;
        step();
        chk("wd_chg_grant", 32'(o_grant), 32'd0);
        step();
        chk("wd_chg_start", 32'(o_tx_start), 32'd0);
        i_tx_busy = 1'b0;
        step();
        chk("busy_drop_ignored", 32'(o_active), 32'd1);

        // Asynchronous reset mid WAIT_DONE
        i_req = 4'b1001;
        i_resetL = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        i_resetL = 1'b1;
        step();
        chk("post_rst_grant", 32'(o_grant), 32'h1);
        chk("post_rst_owner", 32'(o_owner), 32'd0);
        chk("post_rst_data",  32'(o_tx_data), 32'h11);
        i_req = 4'b0000;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("post_rst_idle", 32'(o_active), 32'd0);

        // Request pulsed only while busy is never granted
        i_req = 4'b0100;
        wait_start("pulse", 4'b0100, 2'd2, 8'h33);
        i_req = 4'b0000;
        i_tx_busy = 1'b1;
        step();
        step();
        i_req = 4'b1000;
        step();
        i_req = 4'b0000;
        step();
        i_tx_done = 1'b1;
        i_tx_busy = 1'b0;
        step();
        i_tx_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("pulse_no_grant", 32'(o_grant), 32'd0);
            chk("pulse_no_active", 32'(o_active), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
